// File: rtl/e203_longp_pkg.sv
// Shared types and sizing for the long-pipe completion tracker.
package e203_longp_pkg;

    localparam int LONGP_DEPTH  = 4;
    localparam int LONGP_ITAG_W = $clog2(LONGP_DEPTH);
    localparam int LONGP_XLEN   = 32;

    typedef struct packed {
        logic [LONGP_XLEN-1:0] wdat;
        logic                  err;
        logic [LONGP_XLEN-1:0] badaddr;
    } cmpl_payload_t;

    localparam int PLD_W = $bits(cmpl_payload_t);

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_MDV = 1'b1
    } cmpl_src_e;

endpackage

// File: rtl/e203_longp_cmpl_slot.sv
// One completion slot: done flag plus captured payload from either long pipe.
module e203_longp_cmpl_slot
    import e203_longp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_lsu_i,
    input  logic             set_mdv_i,
    input  logic             clr_i,
    input  logic [PLD_W-1:0] lsu_pld_i,
    input  logic [PLD_W-1:0] mdv_pld_i,
    output logic             done_o,
    output logic [PLD_W-1:0] pld_o
);

    logic             done_q, done_d;
    logic [PLD_W-1:0] pld_q, pld_d;
    cmpl_src_e        src_sel;

    // A new completion beats a retire clear of the same slot (tag re-allocated).
    always_comb begin
        done_d = done_q;
        if (set_lsu_i || set_mdv_i) begin
            done_d = 1'b1;
        end else if (clr_i) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        src_sel = set_lsu_i ? SRC_LSU : SRC_MDV;
        pld_d   = pld_q;
        if (set_lsu_i || set_mdv_i) begin
            pld_d = (src_sel == SRC_LSU) ? lsu_pld_i : mdv_pld_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    // Payload is only meaningful while done is set, so it carries no reset.
    always_ff @(posedge clk) begin
        pld_q <= pld_d;
    end

    assign done_o = done_q;
    assign pld_o  = pld_q;

endmodule

// File: rtl/e203_exu_longp_cmpl.sv
// Long-pipe completion side of the OITF: out-of-order capture, in-order retire.
module e203_exu_longp_cmpl
    import e203_longp_pkg::*;
#(
    parameter int DEPTH   = LONGP_DEPTH,
    parameter int ITAG_W  = LONGP_ITAG_W,
    parameter int RFIDX_W = 5,
    parameter int XLEN    = LONGP_XLEN,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_cmpl_valid,
    output logic               lsu_cmpl_ready,
    input  logic [ITAG_W-1:0]  lsu_cmpl_itag,
    input  logic [XLEN-1:0]    lsu_cmpl_wdat,
    input  logic               lsu_cmpl_err,
    input  logic [XLEN-1:0]    lsu_cmpl_badaddr,
    input  logic               mdv_cmpl_valid,
    output logic               mdv_cmpl_ready,
    input  logic [ITAG_W-1:0]  mdv_cmpl_itag,
    input  logic [XLEN-1:0]    mdv_cmpl_wdat,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    input  logic               oitf_ret_rdfpu,
    input  logic [PC_W-1:0]    oitf_ret_pc,
    input  logic               oitf_empty,
    output logic               oitf_ret_ena,
    output logic               wbck_o_valid,
    input  logic               wbck_o_ready,
    output logic [RFIDX_W-1:0] wbck_o_rdidx,
    output logic               wbck_o_rdfpu,
    output logic [XLEN-1:0]    wbck_o_wdat,
    output logic               excp_o_valid,
    input  logic               excp_o_ready,
    output logic [PC_W-1:0]    excp_o_pc,
    output logic [XLEN-1:0]    excp_o_badaddr
);

    logic [DEPTH-1:0] done_vec;
    logic [PLD_W-1:0] slot_pld [DEPTH];
    cmpl_payload_t    lsu_pld, mdv_pld, head_pld;
    logic             lsu_fire, mdv_fire, head_done, retire;

    assign lsu_cmpl_ready = ~done_vec[lsu_cmpl_itag];
    assign mdv_cmpl_ready = ~done_vec[mdv_cmpl_itag];
    assign lsu_fire       = lsu_cmpl_valid & lsu_cmpl_ready;
    assign mdv_fire       = mdv_cmpl_valid & mdv_cmpl_ready;

    always_comb begin
        lsu_pld = '{wdat: lsu_cmpl_wdat, err: lsu_cmpl_err, badaddr: lsu_cmpl_badaddr};
        mdv_pld = '{wdat: mdv_cmpl_wdat, err: 1'b0, badaddr: '0};
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        e203_longp_cmpl_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .set_lsu_i (lsu_fire && (lsu_cmpl_itag == ITAG_W'(i))),
            .set_mdv_i (mdv_fire && (mdv_cmpl_itag == ITAG_W'(i))),
            .clr_i     (retire && (oitf_ret_ptr == ITAG_W'(i))),
            .lsu_pld_i (lsu_pld),
            .mdv_pld_i (mdv_pld),
            .done_o    (done_vec[i]),
            .pld_o     (slot_pld[i])
        );
    end

    // Valid/ready: a request holds valid with stable payload until ready is seen;
    // the transfer (and the retire) happens on the cycle both are high.
    always_comb begin
        head_pld  = cmpl_payload_t'(slot_pld[oitf_ret_ptr]);
        head_done = done_vec[oitf_ret_ptr] & ~oitf_empty;
        excp_o_valid = head_done & head_pld.err;
        wbck_o_valid = head_done & ~head_pld.err & oitf_ret_rdwen;
        if (head_pld.err) begin
            retire = head_done & excp_o_ready;
        end else if (oitf_ret_rdwen) begin
            retire = head_done & wbck_o_ready;
        end else begin
            retire = head_done;
        end
    end

    assign oitf_ret_ena   = retire;
    assign wbck_o_rdidx   = oitf_ret_rdidx;
    assign wbck_o_rdfpu   = oitf_ret_rdfpu;
    assign wbck_o_wdat    = head_pld.wdat;
    assign excp_o_pc      = oitf_ret_pc;
    assign excp_o_badaddr = head_pld.badaddr;

    a_no_same_tag: assert property (@(posedge clk) disable iff (rst)
        !(lsu_cmpl_valid && mdv_cmpl_valid && (lsu_cmpl_itag == mdv_cmpl_itag)));
    a_lsu_not_done: assert property (@(posedge clk) disable iff (rst)
        lsu_fire |-> !done_vec[lsu_cmpl_itag]);
    a_mdv_not_done: assert property (@(posedge clk) disable iff (rst)
        mdv_fire |-> !done_vec[mdv_cmpl_itag]);
    a_no_retire_empty: assert property (@(posedge clk) disable iff (rst)
        oitf_empty |-> !retire);

endmodule
